// File: rtl/key_match_game.sv
// Keypad reaction game: debounces one-hot scanner pulses into single key events
// and runs a timed "press the lit key" game for a fixed number of rounds.
module key_match_game #(
  parameter int ROUNDS  = 10,
  parameter int TIMEOUT = 50000000,
  parameter int SHOW    = 12500000,
  parameter int RELEASE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] dot,
  output logic        switch,
  output logic        finish,
  output logic [15:0] target,
  output logic [7:0]  score,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HIT  = 3'd3;
  localparam logic [2:0] S_MISS = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int              RW        = $clog2(RELEASE + 1);
  localparam logic [RW-1:0]   REL_MAX   = RW'(RELEASE);
  localparam logic [RW-1:0]   REL_LAST  = RW'(RELEASE - 1);
  localparam logic [31:0]     WAIT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0]     SHOW_LAST = 32'(SHOW - 1);
  localparam logic [7:0]      ROUNDS_C  = 8'(ROUNDS);

  logic [2:0]    r_state;
  logic [15:0]   r_lfsr;
  logic [3:0]    r_idx;
  logic [7:0]    r_round;
  logic [31:0]   r_timer;
  logic          r_pressed;
  logic [RW-1:0] r_rel_cnt;

  logic       w_one_hot;
  logic [3:0] w_dot_idx;
  logic [3:0] w_new_idx;
  logic       w_fb;
  logic [7:0] w_round_nxt;

  always_comb begin
    w_one_hot = (dot != 16'h0000) && ((dot & (dot - 16'd1)) == 16'h0000);
    w_dot_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (dot[i]) w_dot_idx = 4'(i);
    end
    // Never light the same key twice in a row; 4-bit add wraps 15 to 0.
    w_new_idx   = (r_lfsr[3:0] == r_idx) ? r_lfsr[3:0] + 4'd1 : r_lfsr[3:0];
    w_fb        = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    w_round_nxt = r_round + 8'd1;
  end

  assign o_dbg_state = r_state;

  // key_valid is a valid-only strobe (no ready): one cycle per fresh press,
  // key_code is meaningful only while key_valid is high.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 16'hACE1;
      r_idx     <= 4'd0;
      r_round   <= 8'd0;
      r_timer   <= 32'd0;
      r_pressed <= 1'b0;
      r_rel_cnt <= '0;
      switch    <= 1'b0;
      finish    <= 1'b0;
      target    <= 16'h0000;
      score     <= 8'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      r_lfsr    <= {w_fb, r_lfsr[15:1]};
      key_valid <= 1'b0;

      // A held key pulses once per scan; only a long quiet gap re-arms it.
      if (dot == 16'h0000) begin
        if (r_rel_cnt != REL_MAX) begin
          r_rel_cnt <= r_rel_cnt + RW'(1);
          if (r_rel_cnt == REL_LAST) r_pressed <= 1'b0;
        end
      end else begin
        r_rel_cnt <= '0;
        if (w_one_hot && !r_pressed) begin
          key_valid <= 1'b1;
          key_code  <= w_dot_idx;
          r_pressed <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_ARM;
            score   <= 8'd0;
            r_round <= 8'd0;
            finish  <= 1'b0;
            switch  <= 1'b1;
            target  <= 16'h0000;
          end
        end
        S_ARM: begin
          target  <= 16'h0001 << w_new_idx;
          r_idx   <= w_new_idx;
          r_timer <= 32'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_timer <= r_timer + 32'd1;
          if (key_valid) begin
            r_timer <= 32'd0;
            if (key_code == r_idx) begin
              r_state <= S_HIT;
              target  <= 16'hFFFF;
              if (score != 8'hFF) score <= score + 8'd1;
            end else begin
              r_state <= S_MISS;
              target  <= 16'h0000;
            end
          end else if (r_timer == WAIT_LAST) begin
            r_timer <= 32'd0;
            r_state <= S_MISS;
            target  <= 16'h0000;
          end
        end
        S_HIT, S_MISS: begin
          r_timer <= r_timer + 32'd1;
          if (r_timer == SHOW_LAST) begin
            r_round <= w_round_nxt;
            target  <= 16'h0000;
            if (w_round_nxt == ROUNDS_C) begin
              r_state <= S_DONE;
              switch  <= 1'b0;
              finish  <= 1'b1;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_match_game.sv
// Bench for key_match_game: table-driven press tracker vectors, hand-written game
// sequences, and a key-event scoreboard fed at stimulus time.
module tb_key_match_game;

  localparam int ROUNDS  = 3;
  localparam int TIMEOUT = 20;
  localparam int SHOW    = 4;
  localparam int RELEASE = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HIT  = 3'd3;
  localparam logic [2:0] S_MISS = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dot   = 16'h0000;
  logic        switch;
  logic        finish;
  logic [15:0] target;
  logic [7:0]  score;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [2:0]  dbg_state;

  key_match_game #(
    .ROUNDS(ROUNDS), .TIMEOUT(TIMEOUT), .SHOW(SHOW), .RELEASE(RELEASE)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .dot(dot),
    .switch(switch), .finish(finish), .target(target), .score(score),
    .key_valid(key_valid), .key_code(key_code), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [3:0]  exp_q[$];
  logic [3:0]  e_code;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_prev;
  logic [3:0]  prev_idx;
  logic [3:0]  cur_idx;
  logic [7:0]  exp_score;

  typedef struct {
    logic [15:0] d;
    int          on_c;
    int          off_c;
    bit          ev;
    logic [3:0]  code;
  } vec_t;

  vec_t vecs[$];

  // Reference LFSR: Fibonacci x^16+x^14+x^13+x^11+1, reloaded while in reset.
  always @(posedge clock) begin
    if (!reset) begin
      lfsr_m <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every key_valid pulse must match the oldest expected code
  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL key_unexpected: got key_code %0d expected no event", key_code);
      end else begin
        e_code = exp_q.pop_front();
        check("key_code", 32'(key_code), 32'(e_code));
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [15:0] d, input int on_c, input int off_c,
                              input bit ev, input logic [3:0] code);
    vec_t v;
    v.d = d; v.on_c = on_c; v.off_c = off_c; v.ev = ev; v.code = code;
    return v;
  endfunction

  task automatic press_key(input logic [3:0] k, input int delay);
    for (int i = 0; i < delay; i++) tick();
    dot = 16'h0001 << k;
    exp_q.push_back(k);
    tick();
    dot = 16'h0000;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_switch"}, 32'(switch), 32'd0);
    check({tag, "_finish"}, 32'(finish), 32'd0);
    check({tag, "_target"}, 32'(target), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    check({tag, "_key_code"}, 32'(key_code), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic check_arm_target(input string tag);
    logic [3:0] ei;
    ei = lfsr_prev[3:0];
    if (ei == prev_idx) ei = ei + 4'd1;
    check({tag, "_target"}, 32'(target), 32'(16'h0001 << ei));
    check({tag, "_not_repeat"}, 32'((target & (16'h0001 << prev_idx)) != 16'h0000), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(S_WAIT));
    check({tag, "_switch"}, 32'(switch), 32'd1);
    prev_idx = ei;
    cur_idx  = ei;
  endtask

  task automatic start_game(input string tag);
    start = 1'b1;
    tick();
    check({tag, "_arm_state"}, 32'(dbg_state), 32'(S_ARM));
    check({tag, "_arm_switch"}, 32'(switch), 32'd1);
    check({tag, "_arm_finish"}, 32'(finish), 32'd0);
    check({tag, "_arm_score"}, 32'(score), 32'd0);
    start = 1'b0;
    exp_score = 8'd0;
    tick();
    check_arm_target(tag);
  endtask

  task automatic show_phase(input string tag, input logic [15:0] pat,
                            input logic [2:0] st, input bit last);
    for (int i = 0; i < SHOW; i++) begin
      check({tag, "_show_target"}, 32'(target), 32'(pat));
      check({tag, "_show_state"}, 32'(dbg_state), 32'(st));
      tick();
    end
    check({tag, "_score"}, 32'(score), 32'(exp_score));
    if (last) begin
      check({tag, "_done_state"}, 32'(dbg_state), 32'(S_DONE));
      check({tag, "_done_finish"}, 32'(finish), 32'd1);
      check({tag, "_done_switch"}, 32'(switch), 32'd0);
      check({tag, "_done_target"}, 32'(target), 32'd0);
    end else begin
      check({tag, "_arm_state"}, 32'(dbg_state), 32'(S_ARM));
      check({tag, "_arm_switch"}, 32'(switch), 32'd1);
      tick();
      check_arm_target({tag, "_next"});
    end
  endtask

  initial begin
    prev_idx  = 4'd0;
    cur_idx   = 4'd0;
    exp_score = 8'd0;

    // reset with start high and dot toggling
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dot = (i % 2 == 1) ? 16'h0010 : 16'h0300;
      tick();
    end
    check_all_zero("reset");
    start = 1'b0;
    dot   = 16'h0000;
    reset = 1'b1;
    tick();
    check_all_zero("idle");

    // press tracker vectors (run in IDLE)
    vecs.push_back(mk(16'h0400, 1, 3, 1'b1, 4'd10));
    for (int i = 0; i < 9; i++) vecs.push_back(mk(16'h0400, 1, 3, 1'b0, 4'd0));
    vecs.push_back(mk(16'h0000, 0, 8, 1'b0, 4'd0));
    vecs.push_back(mk(16'h0400, 1, 8, 1'b1, 4'd10));
    vecs.push_back(mk(16'h0003, 2, 8, 1'b0, 4'd0));
    vecs.push_back(mk(16'h0001, 3, 8, 1'b1, 4'd0));
    vecs.push_back(mk(16'h8000, 1, 8, 1'b1, 4'd15));
    vecs.push_back(mk(16'h0020, 1, 3, 1'b1, 4'd5));
    vecs.push_back(mk(16'h0040, 1, 8, 1'b0, 4'd0));
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].ev) exp_q.push_back(vecs[i].code);
      for (int c = 0; c < vecs[i].on_c; c++) begin
        dot = vecs[i].d;
        tick();
      end
      dot = 16'h0000;
      for (int c = 0; c < vecs[i].off_c; c++) tick();
    end
    tick();
    check("table_events_drained", 32'(exp_q.size()), 32'd0);
    check("table_state", 32'(dbg_state), 32'(S_IDLE));

    // game 1: hit, wrong key, timeout
    start_game("g1");
    press_key(cur_idx, 6);
    exp_score = exp_score + 8'd1;
    check("g1r1_hit_state", 32'(dbg_state), 32'(S_HIT));
    show_phase("g1r1", 16'hFFFF, S_HIT, 1'b0);
    press_key(cur_idx + 4'd1, 6);
    check("g1r2_miss_state", 32'(dbg_state), 32'(S_MISS));
    show_phase("g1r2", 16'h0000, S_MISS, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("g1r3_wait_edge", 32'(dbg_state), 32'(S_WAIT));
    tick();
    check("g1r3_timeout_state", 32'(dbg_state), 32'(S_MISS));
    show_phase("g1r3", 16'h0000, S_MISS, 1'b1);

    // game 2: hit, hit on the timeout cycle, miss
    start_game("g2");
    press_key(cur_idx, 6);
    exp_score = exp_score + 8'd1;
    check("g2r1_hit_state", 32'(dbg_state), 32'(S_HIT));
    show_phase("g2r1", 16'hFFFF, S_HIT, 1'b0);
    press_key(cur_idx, TIMEOUT - 2);
    exp_score = exp_score + 8'd1;
    check("g2r2_key_beats_timeout", 32'(dbg_state), 32'(S_HIT));
    show_phase("g2r2", 16'hFFFF, S_HIT, 1'b0);
    press_key(cur_idx + 4'd1, 6);
    check("g2r3_miss_state", 32'(dbg_state), 32'(S_MISS));
    show_phase("g2r3", 16'h0000, S_MISS, 1'b1);
    check("g2_final_score", 32'(score), 32'd2);

    // key activity in DONE leaves the score alone
    press_key(4'd7, 4);
    check("done_key_state", 32'(dbg_state), 32'(S_DONE));
    check("done_key_score", 32'(score), 32'd2);
    check("done_key_finish", 32'(finish), 32'd1);

    // game 3: restart from DONE, then reset in the middle of HIT
    start_game("g3");
    press_key(cur_idx, 6);
    check("g3r1_hit_state", 32'(dbg_state), 32'(S_HIT));
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("midreset");
    reset    = 1'b1;
    prev_idx = 4'd0;
    dot      = 16'h0003;
    tick();
    tick();
    dot = 16'h0000;
    tick();
    check("two_bits_no_event", 32'(key_valid), 32'd0);
    tick();
    press_key(4'd9, 0);
    tick();
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_state", 32'(dbg_state), 32'(S_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
